blake2_block_ctrl: RTL and testbench
====================================

# blake2_block_ctrl

Message-block sequencer between the byte-wide I/O interface and the BLAKE2s compression core. It latches the configuration (key length, digest length, message length) at message start. It writes incoming bytes into the 64-byte message buffer, zero-pads the final block, and launches one compression per block with the correct byte counter and first/last flags. After the final compression it streams the digest read-out indices.

## Interface
Parameters: none (block size fixed at 64 bytes, digest ≤ 32 bytes).
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse: begin new message, latch kk_i/nn_i/ll_i
- kk_i  in  6  key length in bytes (0..32)
- nn_i  in  6  digest length in bytes (1..32)
- ll_i  in  64  message length in bytes (excluding key)
- data_v_i  in  1  message/key byte valid
- data_i  in  8  byte value
- data_idx_i  in  6  byte position within current block
- block_last_i  in  1  current block is the final block
- ready_o  out  1  controller accepting bytes (high only in FILL)
- m_we_o  out  1  message buffer write enable
- m_addr_o  out  6  message buffer byte address
- m_data_o  out  8  message buffer write data
- comp_start_o  out  1  one-cycle compression launch pulse
- comp_first_o  out  1  first block of message (core re-initialises h); valid with comp_start_o
- comp_last_o  out  1  final block (core inverts v[14]); valid with comp_start_o
- comp_t_o  out  64  byte counter t; valid with comp_start_o
- comp_done_i  in  1  one-cycle pulse: compression finished
- hash_req_o  out  1  digest byte request
- hash_idx_o  out  5  digest byte index
- done_o  out  1  one-cycle pulse: digest read-out complete
- err_o  out  1  sticky protocol error; cleared by reset or start_i

## Operation
- Registers: state, kk/nn/total (total = ll + (kk≠0 ? 64 : 0), 64-bit, mod 2^64), t counter (64-bit, wraps mod 2^64), byte pointer ptr[6:0], first-block flag, last-block flag, hash counter.
- When kk≠0, the host sends the zero-padded key block as the first 64 data bytes; the controller counts it like any other block.
- States:
  - IDLE: ready_o=0. On start_i: latch config, t=0, first=1, ptr=0, clear err_o. Go to PAD if total==0, else FILL.
  - FILL: ready_o=1. Each data_v_i writes data_i at data_idx_i, t+=1, ptr=data_idx_i+1. The block ends when data_idx_i==63, or when block_last_i=1 and t+1==total; latch last=block_last_i. Next state is COMP if ptr reaches 64, else PAD.
  - PAD: one zero write per cycle at ptr, ptr+=1, up to and including address 63, then COMP.
  - COMP: comp_start_o pulses on the first COMP cycle, with comp_t_o=t, comp_first_o=first, comp_last_o=last. Wait for comp_done_i. Then clear first; go to OUT if last, else FILL with ptr=0.
  - OUT: hash_req_o=1 with hash_idx_o=0..nn-1, one per cycle. done_o pulses with the last index. Then IDLE.
- Empty message (total==0): one all-zero block, t=0, first=last=1.
- Errors (set err_o, byte dropped, no write, t unchanged):
  - data_v_i outside FILL.
  - data_idx_i ≠ ptr[5:0].
  - block_last_i=1 at data_idx_i==63 with t+1≠total.
- start_i outside IDLE: ignored, err_o set.
- comp_done_i outside COMP: ignored.

## Timing
- Reset: state IDLE. All outputs 0, including ready_o, m_we_o, comp_start_o, comp_*, hash_req_o, hash_idx_o, done_o and err_o.
- Reset asserted mid-message (any state) returns to IDLE on the next edge. No pending write or pulse is emitted.
- m_we_o/m_addr_o/m_data_o are registered: the write appears 1 cycle after the accepted data_v_i.
- The first PAD write follows the last data write on the next cycle. A full 64-byte block enters COMP the cycle after its last write.
- comp_start_o follows the final buffer write by ≥1 cycle. It is never asserted in the same cycle as any m_we_o.
- OUT: hash_req_o for nn consecutive cycles, starting the cycle after comp_done_i. done_o coincides with hash_idx_o = nn-1.
- ready_o drops the cycle after the terminating byte is accepted.

## Test plan
- kk=0, nn=32, ll=3, bytes idx 0..2 with block_last_i -> writes addr 0..2, then 61 zero writes addr 3..63. comp_start_o with t=3, first=1, last=1. After done: hash_idx_o 0..31, then done_o.
- kk=0, ll=0 -> 64 zero writes, comp t=0, first=last=1, no FILL cycles.
- ll=128, two full blocks -> comp (t=64, first=1, last=0), then (t=128, first=0, last=1), no PAD writes.
- kk=16, ll=0, 64-byte key block with block_last_i -> comp t=64, first=last=1.
- data_v_i pulsed during COMP, and a byte with data_idx_i=5 when ptr=4 -> no m_we_o, t unchanged, err_o=1 until next start_i.
- reset asserted in PAD at ptr=20 -> next cycle IDLE, all outputs 0. A following start_i runs a normal message.

Source files
------------

// File: rtl/blake2_block_ctrl.sv
// Message-block sequencer for a BLAKE2s core: buffers host bytes, zero-pads the
// final block, launches one compression per block and streams digest indices.
module blake2_block_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [5:0]  kk_i,
  input  logic [5:0]  nn_i,
  input  logic [63:0] ll_i,
  input  logic        data_v_i,
  input  logic [7:0]  data_i,
  input  logic [5:0]  data_idx_i,
  input  logic        block_last_i,
  output logic        ready_o,
  output logic        m_we_o,
  output logic [5:0]  m_addr_o,
  output logic [7:0]  m_data_o,
  output logic        comp_start_o,
  output logic        comp_first_o,
  output logic        comp_last_o,
  output logic [63:0] comp_t_o,
  input  logic        comp_done_i,
  output logic        hash_req_o,
  output logic [4:0]  hash_idx_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {StIdle, StFill, StPad, StComp, StOut} state_e;

  state_e      state_q, state_d;
  logic [5:0]  nn_q, nn_d;
  logic [63:0] total_q, total_d;
  logic [63:0] t_q, t_d;
  logic [6:0]  ptr_q, ptr_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        issued_q, issued_d;
  logic [4:0]  hash_cnt_q, hash_cnt_d;
  logic        err_q, err_d;
  logic        m_we_q, m_we_d;
  logic [5:0]  m_addr_q, m_addr_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        comp_start_q, comp_start_d;
  logic        comp_first_q, comp_first_d;
  logic        comp_last_q, comp_last_d;
  logic [63:0] comp_t_q, comp_t_d;

  logic [63:0] total_new;
  logic [63:0] t_inc;
  logic [6:0]  ptr_nxt;
  logic [6:0]  pad_nxt;
  logic        byte_ok;
  logic        block_end;
  logic        hash_last;

  assign total_new = ll_i + ((kk_i != 6'd0) ? 64'd64 : 64'd0);
  assign t_inc     = t_q + 64'd1;
  assign ptr_nxt   = {1'b0, data_idx_i} + 7'd1;
  assign pad_nxt   = ptr_q + 7'd1;
  // A final-block flag on byte 63 must agree with the byte count.
  assign byte_ok   = (data_idx_i == ptr_q[5:0]) &&
                     !(block_last_i && (data_idx_i == 6'd63) && (t_inc != total_q));
  assign block_end = (data_idx_i == 6'd63) || (block_last_i && (t_inc == total_q));
  // The 31 cap keeps an out-of-range nn from stalling read-out forever.
  assign hash_last = ({1'b0, hash_cnt_q} == (nn_q - 6'd1)) || (hash_cnt_q == 5'd31);

  always_comb begin
    state_d      = state_q;
    nn_d         = nn_q;
    total_d      = total_q;
    t_d          = t_q;
    ptr_d        = ptr_q;
    first_d      = first_q;
    last_d       = last_q;
    issued_d     = issued_q;
    hash_cnt_d   = hash_cnt_q;
    err_d        = err_q;
    m_we_d       = 1'b0;
    m_addr_d     = 6'd0;
    m_data_d     = 8'd0;
    comp_start_d = 1'b0;
    comp_first_d = 1'b0;
    comp_last_d  = 1'b0;
    comp_t_d     = 64'd0;

    if (data_v_i && (state_q != StFill)) err_d = 1'b1;
    if (start_i && (state_q != StIdle)) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          nn_d     = nn_i;
          total_d  = total_new;
          t_d      = 64'd0;
          first_d  = 1'b1;
          ptr_d    = 7'd0;
          issued_d = 1'b0;
          err_d    = 1'b0;
          if (total_new == 64'd0) begin
            last_d  = 1'b1;
            state_d = StPad;
          end else begin
            last_d  = 1'b0;
            state_d = StFill;
          end
        end
      end

      StFill: begin
        if (data_v_i) begin
          if (!byte_ok) begin
            err_d = 1'b1;
          end else begin
            m_we_d   = 1'b1;
            m_addr_d = data_idx_i;
            m_data_d = data_i;
            t_d      = t_inc;
            ptr_d    = ptr_nxt;
            if (block_end) begin
              last_d  = block_last_i;
              state_d = ptr_nxt[6] ? StComp : StPad;
            end
          end
        end
      end

      StPad: begin
        m_we_d   = 1'b1;
        m_addr_d = ptr_q[5:0];
        m_data_d = 8'd0;
        ptr_d    = pad_nxt;
        if (pad_nxt[6]) state_d = StComp;
      end

      StComp: begin
        // Launch is registered, so it lands after the last buffer write settles.
        if (!issued_q) begin
          issued_d     = 1'b1;
          comp_start_d = 1'b1;
          comp_first_d = first_q;
          comp_last_d  = last_q;
          comp_t_d     = t_q;
        end else if (comp_done_i) begin
          issued_d = 1'b0;
          first_d  = 1'b0;
          if (last_q) begin
            hash_cnt_d = 5'd0;
            state_d    = StOut;
          end else begin
            ptr_d   = 7'd0;
            state_d = StFill;
          end
        end
      end

      StOut: begin
        hash_cnt_d = hash_cnt_q + 5'd1;
        if (hash_last) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      nn_q         <= 6'd0;
      total_q      <= 64'd0;
      t_q          <= 64'd0;
      ptr_q        <= 7'd0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      issued_q     <= 1'b0;
      hash_cnt_q   <= 5'd0;
      err_q        <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= 6'd0;
      m_data_q     <= 8'd0;
      comp_start_q <= 1'b0;
      comp_first_q <= 1'b0;
      comp_last_q  <= 1'b0;
      comp_t_q     <= 64'd0;
    end else begin
      state_q      <= state_d;
      nn_q         <= nn_d;
      total_q      <= total_d;
      t_q          <= t_d;
      ptr_q        <= ptr_d;
      first_q      <= first_d;
      last_q       <= last_d;
      issued_q     <= issued_d;
      hash_cnt_q   <= hash_cnt_d;
      err_q        <= err_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_data_q     <= m_data_d;
      comp_start_q <= comp_start_d;
      comp_first_q <= comp_first_d;
      comp_last_q  <= comp_last_d;
      comp_t_q     <= comp_t_d;
    end
  end

  assign ready_o      = (state_q == StFill);
  assign m_we_o       = m_we_q;
  assign m_addr_o     = m_addr_q;
  assign m_data_o     = m_data_q;
  assign comp_start_o = comp_start_q;
  assign comp_first_o = comp_first_q;
  assign comp_last_o  = comp_last_q;
  assign comp_t_o     = comp_t_q;
  assign hash_req_o   = (state_q == StOut);
  assign hash_idx_o   = hash_req_o ? hash_cnt_q : 5'd0;
  assign done_o       = hash_req_o && hash_last;
  assign err_o        = err_q;

endmodule

// File: tb/tb_blake2_block_ctrl.sv
// Directed bench for blake2_block_ctrl: expected writes, launches and digest
// indices are queued as stimulus is driven and checked as the DUT emits them.
module tb_blake2_block_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  kk_i = '0;
  logic [5:0]  nn_i = '0;
  logic [63:0] ll_i = '0;
  logic        data_v_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic [5:0]  data_idx_i = '0;
  logic        block_last_i = 1'b0;
  logic        comp_done_i = 1'b0;
  logic        ready_o, m_we_o, comp_start_o, comp_first_o, comp_last_o;
  logic        hash_req_o, done_o, err_o;
  logic [5:0]  m_addr_o;
  logic [7:0]  m_data_o;
  logic [63:0] comp_t_o;
  logic [4:0]  hash_idx_o;

  int vectors = 0;
  int miscompares = 0;

  logic [13:0] wq[$];
  logic [65:0] cq[$];
  logic [5:0]  hq[$];

  logic [90:0] all_out;
  assign all_out = {ready_o, m_we_o, m_addr_o, m_data_o, comp_start_o, comp_first_o,
                    comp_last_o, comp_t_o, hash_req_o, hash_idx_o, done_o, err_o};

  blake2_block_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .kk_i         (kk_i),
    .nn_i         (nn_i),
    .ll_i         (ll_i),
    .data_v_i     (data_v_i),
    .data_i       (data_i),
    .data_idx_i   (data_idx_i),
    .block_last_i (block_last_i),
    .ready_o      (ready_o),
    .m_we_o       (m_we_o),
    .m_addr_o     (m_addr_o),
    .m_data_o     (m_data_o),
    .comp_start_o (comp_start_o),
    .comp_first_o (comp_first_o),
    .comp_last_o  (comp_last_o),
    .comp_t_o     (comp_t_o),
    .comp_done_i  (comp_done_i),
    .hash_req_o   (hash_req_o),
    .hash_idx_o   (hash_idx_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every emitted write/launch/index must match the head of its queue.
  always @(negedge clk) begin
    logic [13:0] w;
    logic [65:0] c;
    logic [5:0]  h;
    if (m_we_o) begin
      check("write_expected", 128'(wq.size() != 0), 128'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        check("write", {m_addr_o, m_data_o}, w);
      end
    end
    if (comp_start_o) begin
      check("comp_no_we", m_we_o, 0);
      check("comp_expected", 128'(cq.size() != 0), 128'd1);
      if (cq.size() != 0) begin
        c = cq.pop_front();
        check("comp", {comp_t_o, comp_first_o, comp_last_o}, c);
      end
    end
    if (hash_req_o) begin
      check("hash_expected", 128'(hq.size() != 0), 128'd1);
      if (hq.size() != 0) begin
        h = hq.pop_front();
        check("hash", {hash_idx_o, done_o}, h);
      end
    end else if (done_o) begin
      check("done_without_req", hash_req_o, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_msg(input logic [5:0] kk, input logic [5:0] nn, input logic [63:0] ll);
    kk_i = kk;
    nn_i = nn;
    ll_i = ll;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic last);
    data_v_i = 1'b1;
    data_idx_i = 6'(idx);
    data_i = d;
    block_last_i = last;
    tick();
    data_v_i = 1'b0;
    block_last_i = 1'b0;
  endtask

  task automatic push_pad(input int from);
    for (int a = from; a < 64; a++) wq.push_back({6'(a), 8'h00});
  endtask

  task automatic push_hash(input int nn);
    for (int i = 0; i < nn; i++) hq.push_back({5'(i), i == nn - 1});
  endtask

  task automatic wait_comp(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!comp_start_o && n < 200);
    check({tag, "_comp_seen"}, comp_start_o, 1);
    tick();
  endtask

  task automatic pulse_done();
    comp_done_i = 1'b1;
    tick();
    comp_done_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 100);
    check({tag, "_done_seen"}, done_o, 1);
    tick();
    check({tag, "_idle_ready"}, ready_o, 0);
    check({tag, "_idle_hash"}, hash_req_o, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_wq_empty"}, wq.size(), 0);
    check({tag, "_cq_empty"}, cq.size(), 0);
    check({tag, "_hq_empty"}, hq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick(); tick();
    check("reset_outputs", all_out, 0);
    reset = 1'b0;
    tick();

    // Short message, single block with padding
    begin_msg(6'd0, 6'd32, 64'd3);
    check("t1_ready", ready_o, 1);
    for (int i = 0; i < 3; i++) wq.push_back({6'(i), 8'(8'hA0 + i)});
    push_pad(3);
    cq.push_back({64'd3, 1'b1, 1'b1});
    push_hash(32);
    for (int i = 0; i < 3; i++) send(i, 8'(8'hA0 + i), i == 2);
    check("t1_ready_drop", ready_o, 0);
    wait_comp("t1");
    pulse_done();
    wait_done("t1");
    check("t1_err", err_o, 0);
    check_drained("t1");

    // Empty message
    begin_msg(6'd0, 6'd4, 64'd0);
    check("t2_no_fill", ready_o, 0);
    push_pad(0);
    cq.push_back({64'd0, 1'b1, 1'b1});
    push_hash(4);
    wait_comp("t2");
    pulse_done();
    wait_done("t2");
    check_drained("t2");

    // Two full blocks, no padding
    begin_msg(6'd0, 6'd8, 64'd128);
    for (int i = 0; i < 64; i++) wq.push_back({6'(i), 8'(i * 3)});
    cq.push_back({64'd64, 1'b1, 1'b0});
    for (int i = 0; i < 64; i++) send(i, 8'(i * 3), 1'b0);
    wait_comp("t3a");
    pulse_done();
    check("t3_refill_ready", ready_o, 1);
    for (int i = 0; i < 64; i++) wq.push_back({6'(i), 8'(255 - i)});
    cq.push_back({64'd128, 1'b0, 1'b1});
    push_hash(8);
    for (int i = 0; i < 64; i++) send(i, 8'(255 - i), i == 63);
    wait_comp("t3b");
    pulse_done();
    wait_done("t3");
    check_drained("t3");

    // Keyed, empty message: key block alone is final
    begin_msg(6'd16, 6'd16, 64'd0);
    for (int i = 0; i < 64; i++) wq.push_back({6'(i), (i < 16) ? 8'(8'h40 + i) : 8'h00});
    cq.push_back({64'd64, 1'b1, 1'b1});
    push_hash(16);
    for (int i = 0; i < 64; i++) send(i, (i < 16) ? 8'(8'h40 + i) : 8'h00, i == 63);
    wait_comp("t4");
    pulse_done();
    wait_done("t4");
    check_drained("t4");

    // Out-of-order byte is dropped and leaves t alone
    begin_msg(6'd0, 6'd1, 64'd10);
    for (int i = 0; i < 10; i++) wq.push_back({6'(i), 8'(i + 16)});
    push_pad(10);
    cq.push_back({64'd10, 1'b1, 1'b1});
    push_hash(1);
    for (int i = 0; i < 4; i++) send(i, 8'(i + 16), 1'b0);
    check("t5_err_clear", err_o, 0);
    send(5, 8'hEE, 1'b0);
    check("t5_err_idx", err_o, 1);
    for (int i = 4; i < 10; i++) send(i, 8'(i + 16), i == 9);
    wait_comp("t5");
    pulse_done();
    wait_done("t5");
    check("t5_err_sticky", err_o, 1);
    check_drained("t5");

    // Byte and start during COMP are rejected
    begin_msg(6'd0, 6'd1, 64'd1);
    check("t5b_err_cleared", err_o, 0);
    wq.push_back({6'd0, 8'h5A});
    push_pad(1);
    cq.push_back({64'd1, 1'b1, 1'b1});
    push_hash(1);
    send(0, 8'h5A, 1'b1);
    wait_comp("t5b");
    data_v_i = 1'b1;
    data_idx_i = 6'd0;
    start_i = 1'b1;
    tick();
    data_v_i = 1'b0;
    start_i = 1'b0;
    check("t5b_err_comp", err_o, 1);
    pulse_done();
    wait_done("t5b");
    check("t5b_err_sticky", err_o, 1);
    check_drained("t5b");

    // Reset in PAD at ptr=20, then a clean message
    begin_msg(6'd0, 6'd2, 64'd20);
    check("t6_err_cleared", err_o, 0);
    for (int i = 0; i < 20; i++) wq.push_back({6'(i), 8'(i ^ 8'h33)});
    for (int i = 0; i < 20; i++) send(i, 8'(i ^ 8'h33), i == 19);
    reset = 1'b1;
    tick();
    check("t6_reset_outputs", all_out, 0);
    reset = 1'b0;
    tick();
    check("t6_no_write_after_reset", all_out, 0);
    check_drained("t6a");
    begin_msg(6'd0, 6'd2, 64'd1);
    wq.push_back({6'd0, 8'hAB});
    push_pad(1);
    cq.push_back({64'd1, 1'b1, 1'b1});
    push_hash(2);
    send(0, 8'hAB, 1'b1);
    wait_comp("t6");
    pulse_done();
    wait_done("t6");
    check("t6_err", err_o, 0);
    check_drained("t6b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
